// File: rtl/dc_exp_handler_if.sv
// Handshake bundle between the dcache exception checker / pipeline and dc_exp_handler.
// exp_shutdown exists only when DC_EXP_DOUBLE_FAULT_EN is defined.
interface dc_exp_handler_if;
  logic        v_ro;
  logic        dc_exp;
  logic        dc_prot_exp;
  logic        dc_page_fault;
  logic        dc_rd_exp;
  logic        dc_wr_exp;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_wr_addr;
  logic [31:0] ro_eip;
  logic        older_empty;
  logic        iret_done;
  logic        exp_stall_ro;
  logic        exp_flush;
  logic        exp_dispatch;
  logic [7:0]  exp_vector;
  logic [31:0] exp_fault_addr;
  logic [31:0] exp_eip;
  logic        isr;
`ifdef DC_EXP_DOUBLE_FAULT_EN
  logic        exp_shutdown;
`endif

  modport master (
    output v_ro, dc_exp, dc_prot_exp, dc_page_fault, dc_rd_exp, dc_wr_exp,
    output mem_rd_addr, mem_wr_addr, ro_eip, older_empty, iret_done,
    input  exp_stall_ro, exp_flush, exp_dispatch, exp_vector, exp_fault_addr,
    input  exp_eip, isr
`ifdef DC_EXP_DOUBLE_FAULT_EN
    , input exp_shutdown
`endif
  );

  modport slave (
    input  v_ro, dc_exp, dc_prot_exp, dc_page_fault, dc_rd_exp, dc_wr_exp,
    input  mem_rd_addr, mem_wr_addr, ro_eip, older_empty, iret_done,
    output exp_stall_ro, exp_flush, exp_dispatch, exp_vector, exp_fault_addr,
    output exp_eip, isr
`ifdef DC_EXP_DOUBLE_FAULT_EN
    , output exp_shutdown
`endif
  );
endinterface

// File: rtl/dc_exp_handler.sv
// Data-cache exception sequencer: capture -> drain -> flush -> dispatch -> ISR.
// Optional double-fault / shutdown handling is enabled by defining DC_EXP_DOUBLE_FAULT_EN.
module dc_exp_handler #(
  parameter logic [7:0]  GP_VECTOR    = 8'h0D,
  parameter logic [7:0]  PF_VECTOR    = 8'h0E,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  dc_exp_handler_if.slave  bus
);

  localparam logic [7:0] DF_VECTOR = 8'h08;

  typedef enum logic [2:0] {
    IDLE, DRAIN, FLUSH, DISPATCH, IN_ISR, SHUTDOWN
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  vec_q, vec_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] eip_q, eip_d;
  logic        df_q, df_d;
  logic        stall_q, stall_d;
  logic        flush_q, flush_d;
  logic        disp_q, disp_d;
  logic        isr_q, isr_d;
  logic        trig;
  logic        accept;

  // Vector choice depends on dc_prot_exp alone; the page-fault and write-side flags
  // are implied by their complements and need no decoding here.
  logic unused_inputs;
  assign unused_inputs = ^{bus.dc_page_fault, bus.dc_wr_exp};

  assign trig = bus.v_ro & bus.dc_exp;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    addr_d  = addr_q;
    eip_d   = eip_q;
    df_d    = df_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig) begin
          accept  = 1'b1;
          state_d = DRAIN;
          eip_d   = bus.ro_eip;
          vec_d   = bus.dc_prot_exp ? GP_VECTOR : PF_VECTOR;
          if (!bus.dc_prot_exp)
            addr_d = bus.dc_rd_exp ? bus.mem_rd_addr : bus.mem_wr_addr;
        end
      end
      DRAIN: begin
        if (bus.older_empty) begin
          state_d = FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = DISPATCH;
      end
      DISPATCH: state_d = IN_ISR;
      IN_ISR: begin
`ifdef DC_EXP_DOUBLE_FAULT_EN
        if (trig && df_q) begin
          state_d = SHUTDOWN;
          vec_d   = '0;
          addr_d  = '0;
          eip_d   = '0;
        end else if (trig) begin
          accept  = 1'b1;
          state_d = DRAIN;
          df_d    = 1'b1;
          vec_d   = DF_VECTOR;
          addr_d  = '0;
          eip_d   = bus.ro_eip;
        end else
`endif
        if (bus.iret_done) begin
          state_d = IDLE;
          df_d    = 1'b0;
        end
      end
      SHUTDOWN: state_d = SHUTDOWN;
      default:  state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    stall_d = (state_d == DRAIN) || (state_d == FLUSH);
    flush_d = (state_d == FLUSH);
    disp_d  = (state_d == DISPATCH);
    isr_d   = (state_d == IN_ISR) || (state_d == SHUTDOWN) || (df_d && (state_d != IDLE));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // NOTE: captured data registers are reset as well because their reset values are visible on outputs.
      vec_q   <= '0;
      addr_q  <= '0;
      eip_q   <= '0;
      df_q    <= 1'b0;
      stall_q <= 1'b0;
      flush_q <= 1'b0;
      disp_q  <= 1'b0;
      isr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      addr_q  <= addr_d;
      eip_q   <= eip_d;
      df_q    <= df_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      disp_q  <= disp_d;
      isr_q   <= isr_d;
    end
  end

  // The faulting instruction must be frozen in the very cycle it is accepted.
  assign bus.exp_stall_ro   = stall_q | accept;
  assign bus.exp_flush      = flush_q;
  assign bus.exp_dispatch   = disp_q;
  assign bus.exp_vector     = vec_q;
  assign bus.exp_fault_addr = addr_q;
  assign bus.exp_eip        = eip_q;
  assign bus.isr            = isr_q;

`ifdef DC_EXP_DOUBLE_FAULT_EN
  logic shut_q;
  always_ff @(posedge clk) begin
    if (rst) shut_q <= 1'b0;
    else     shut_q <= (state_d == SHUTDOWN);
  end
  assign bus.exp_shutdown = shut_q;
`endif

endmodule

// File: tb/tb_dc_exp_handler.sv
// Self-checking bench for dc_exp_handler: directed vector table, hand sequences for
// multi-cycle corners, and randomized stimulus against a cycle-count reference model.
module tb_dc_exp_handler;
  localparam int         FC = 2;
  localparam logic [7:0] GP = 8'h0D;
  localparam logic [7:0] PF = 8'h0E;
  localparam logic [7:0] DF = 8'h08;
  localparam logic [31:0] P = 32'h0040_3123;
`ifdef DC_EXP_DOUBLE_FAULT_EN
  localparam bit DF_EN = 1'b1;
`else
  localparam bit DF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  dc_exp_handler_if bus ();

  dc_exp_handler #(.GP_VECTOR(GP), .PF_VECTOR(PF), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, v_ro, dc_exp, prot, pf, rd, wr;
    logic [31:0] rda, wra, eip;
    logic older, iret;
  } in_t;
  typedef struct {
    logic stall, flush, disp;
    logic [7:0] vec;
    logic [31:0] addr, eip;
    logic isr, shut;
  } out_t;
  typedef struct { in_t i; out_t o; } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic in_t idle_in(logic older, logic iret);
    in_t r;
    r = '{rst:1'b0, v_ro:1'b0, dc_exp:1'b0, prot:1'b0, pf:1'b0, rd:1'b0, wr:1'b0,
          rda:'0, wra:'0, eip:'0, older:older, iret:iret};
    return r;
  endfunction

  function automatic in_t trig_in(logic prot, logic rd, logic wr,
                                  logic [31:0] rda, logic [31:0] wra, logic [31:0] eip);
    in_t r;
    r = idle_in(1'b1, 1'b0);
    r.v_ro = 1'b1; r.dc_exp = 1'b1; r.prot = prot; r.pf = ~prot;
    r.rd = rd; r.wr = wr; r.rda = rda; r.wra = wra; r.eip = eip;
    return r;
  endfunction

  function automatic out_t mk(logic stall, logic flush, logic disp, logic isr,
                              logic [7:0] vec, logic [31:0] addr, logic [31:0] eip);
    out_t o;
    o = '{stall:stall, flush:flush, disp:disp, vec:vec, addr:addr, eip:eip, isr:isr, shut:1'b0};
    return o;
  endfunction

  task automatic drive(input in_t i);
    rst                = i.rst;
    bus.v_ro           = i.v_ro;
    bus.dc_exp         = i.dc_exp;
    bus.dc_prot_exp    = i.prot;
    bus.dc_page_fault  = i.pf;
    bus.dc_rd_exp      = i.rd;
    bus.dc_wr_exp      = i.wr;
    bus.mem_rd_addr    = i.rda;
    bus.mem_wr_addr    = i.wra;
    bus.ro_eip         = i.eip;
    bus.older_empty    = i.older;
    bus.iret_done      = i.iret;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    check({tag, ".stall"}, 32'(bus.exp_stall_ro),  32'(e.stall));
    check({tag, ".flush"}, 32'(bus.exp_flush),     32'(e.flush));
    check({tag, ".disp"},  32'(bus.exp_dispatch),  32'(e.disp));
    check({tag, ".vec"},   32'(bus.exp_vector),    32'(e.vec));
    check({tag, ".addr"},  bus.exp_fault_addr,     e.addr);
    check({tag, ".eip"},   bus.exp_eip,            e.eip);
    check({tag, ".isr"},   32'(bus.isr),           32'(e.isr));
`ifdef DC_EXP_DOUBLE_FAULT_EN
    check({tag, ".shut"},  32'(bus.exp_shutdown),  32'(e.shut));
`endif
  endtask

  // One clock: inputs change just after the rising edge, outputs are checked on the falling edge.
  task automatic cycle(input in_t i, input out_t e, input string tag, input bit chk);
    @(posedge clk);
    #1 drive(i);
    @(negedge clk);
    if (chk) check_out(tag, e);
  endtask

  task automatic do_reset();
    in_t r;
    r = idle_in(1'b1, 1'b0);
    r.rst = 1'b1;
    cycle(r, mk(0, 0, 0, 0, 0, 0, 0), "rst", 1'b0);
    cycle(r, mk(0, 0, 0, 0, 0, 0, 0), "rst", 1'b0);
  endtask

  // Reference model: tracks the sequence by absolute cycle numbers (when the flush window
  // opens and when dispatch is due) rather than by a state register.
  int          cyc, m_flush_at, m_disp_at;
  bit          m_seq, m_drain, m_isr, m_df, m_shut;
  logic [7:0]  m_vec;
  logic [31:0] m_addr, m_eip;

  function automatic void m_reset();
    cyc = 0; m_flush_at = 0; m_disp_at = 0;
    m_seq = 0; m_drain = 0; m_isr = 0; m_df = 0; m_shut = 0;
    m_vec = '0; m_addr = '0; m_eip = '0;
  endfunction

  function automatic bit m_accept(in_t i);
    bit t;
    t = i.v_ro & i.dc_exp;
    if (m_shut || m_seq) return 1'b0;
    if (!m_isr) return t;
    return t & DF_EN & !m_df;
  endfunction

  function automatic out_t m_out(in_t i);
    out_t o;
    o = mk(0, 0, 0, m_isr, m_vec, m_addr, m_eip);
    if (m_shut) begin
      o = mk(0, 0, 0, 1, 0, 0, 0);
      o.shut = 1'b1;
    end else if (m_seq) begin
      if (m_drain)             o.stall = 1'b1;
      else if (cyc < m_disp_at) begin o.stall = 1'b1; o.flush = 1'b1; end
      else                     o.disp = 1'b1;
    end else if (m_accept(i)) begin
      o.stall = 1'b1;
    end
    return o;
  endfunction

  function automatic void m_step(in_t i);
    bit t;
    t = i.v_ro & i.dc_exp;
    if (i.rst) begin
      m_reset();
      return;
    end
    if (m_shut) begin
      // sticky
    end else if (m_seq) begin
      if (m_drain && i.older) begin
        m_drain = 0; m_flush_at = cyc + 1; m_disp_at = cyc + 1 + FC;
      end else if (!m_drain && cyc == m_disp_at) begin
        m_seq = 0; m_isr = 1;
      end
    end else if (m_isr) begin
      if (DF_EN && t && m_df) begin
        m_shut = 1; m_vec = '0; m_addr = '0; m_eip = '0;
      end else if (DF_EN && t) begin
        m_df = 1; m_seq = 1; m_drain = 1; m_vec = DF; m_addr = '0; m_eip = i.eip;
      end else if (i.iret) begin
        m_isr = 0; m_df = 0;
      end
    end else if (t) begin
      m_seq = 1; m_drain = 1; m_eip = i.eip;
      m_vec = i.prot ? GP : PF;
      if (!i.prot) m_addr = i.rd ? i.rda : i.wra;
    end
    cyc++;
  endfunction

  vec_t tbl[17];

  initial begin
    in_t  t;
    out_t s;
    drive(idle_in(1'b1, 1'b0));
    rst = 1'b1;

    // Read page fault, then write protection fault, each closed by iret.
    tbl[0]  = '{idle_in(1, 1),                         mk(0, 0, 0, 0, 0,  0, 0)};
    tbl[1]  = '{trig_in(0, 1, 0, P, 0, 32'h1000),      mk(1, 0, 0, 0, 0,  0, 0)};
    tbl[2]  = '{idle_in(1, 0),                         mk(1, 0, 0, 0, PF, P, 32'h1000)};
    tbl[3]  = '{idle_in(1, 0),                         mk(1, 1, 0, 0, PF, P, 32'h1000)};
    tbl[4]  = '{idle_in(1, 0),                         mk(1, 1, 0, 0, PF, P, 32'h1000)};
    tbl[5]  = '{idle_in(1, 0),                         mk(0, 0, 1, 0, PF, P, 32'h1000)};
    tbl[6]  = '{idle_in(1, 0),                         mk(0, 0, 0, 1, PF, P, 32'h1000)};
    tbl[7]  = '{idle_in(1, 1),                         mk(0, 0, 0, 1, PF, P, 32'h1000)};
    tbl[8]  = '{idle_in(1, 0),                         mk(0, 0, 0, 0, PF, P, 32'h1000)};
    tbl[9]  = '{trig_in(1, 0, 1, 0, 32'hFFFF, 32'h2000), mk(1, 0, 0, 0, PF, P, 32'h1000)};
    tbl[10] = '{idle_in(1, 0),                         mk(1, 0, 0, 0, GP, P, 32'h2000)};
    tbl[11] = '{idle_in(1, 0),                         mk(1, 1, 0, 0, GP, P, 32'h2000)};
    tbl[12] = '{idle_in(1, 0),                         mk(1, 1, 0, 0, GP, P, 32'h2000)};
    tbl[13] = '{idle_in(1, 0),                         mk(0, 0, 1, 0, GP, P, 32'h2000)};
    tbl[14] = '{idle_in(1, 0),                         mk(0, 0, 0, 1, GP, P, 32'h2000)};
    tbl[15] = '{idle_in(1, 1),                         mk(0, 0, 0, 1, GP, P, 32'h2000)};
    tbl[16] = '{idle_in(1, 0),                         mk(0, 0, 0, 0, GP, P, 32'h2000)};

    do_reset();
    for (int k = 0; k < 17; k++)
      cycle(tbl[k].i, tbl[k].o, $sformatf("tbl%0d", k), 1'b1);

    // Drain hold: older instructions retire only after five waiting cycles.
    t = trig_in(0, 1, 0, 32'h5000, 0, 32'h3000);
    t.older = 1'b0;
    cycle(t, mk(1, 0, 0, 0, GP, P, 32'h2000), "hold_trig", 1'b1);
    for (int k = 1; k <= 5; k++)
      cycle(idle_in(0, 0), mk(1, 0, 0, 0, PF, 32'h5000, 32'h3000), $sformatf("hold%0d", k), 1'b1);
    cycle(idle_in(1, 0), mk(1, 0, 0, 0, PF, 32'h5000, 32'h3000), "hold6", 1'b1);
    cycle(idle_in(1, 0), mk(1, 1, 0, 0, PF, 32'h5000, 32'h3000), "hold7_flush", 1'b1);
    cycle(idle_in(1, 0), mk(1, 1, 0, 0, PF, 32'h5000, 32'h3000), "hold8_flush", 1'b1);
    cycle(idle_in(1, 0), mk(0, 0, 1, 0, PF, 32'h5000, 32'h3000), "hold9_disp", 1'b1);
    cycle(idle_in(1, 1), mk(0, 0, 0, 1, PF, 32'h5000, 32'h3000), "hold_iret", 1'b1);

    // Both sides faulting picks the read address; exceptions in FLUSH/DISPATCH are squashed.
    cycle(trig_in(0, 1, 1, 32'hA000, 32'hB000, 32'h4000),
          mk(1, 0, 0, 0, PF, 32'h5000, 32'h3000), "rdwr_trig", 1'b1);
    cycle(idle_in(1, 0), mk(1, 0, 0, 0, PF, 32'hA000, 32'h4000), "rdwr_drain", 1'b1);
    t = trig_in(1, 0, 1, 32'hC000, 32'hD000, 32'h5000);
    cycle(t, mk(1, 1, 0, 0, PF, 32'hA000, 32'h4000), "squash_f1", 1'b1);
    cycle(t, mk(1, 1, 0, 0, PF, 32'hA000, 32'h4000), "squash_f2", 1'b1);
    cycle(t, mk(0, 0, 1, 0, PF, 32'hA000, 32'h4000), "squash_disp", 1'b1);
    cycle(idle_in(1, 0), mk(0, 0, 0, 1, PF, 32'hA000, 32'h4000), "squash_isr", 1'b1);
    cycle(idle_in(1, 1), mk(0, 0, 0, 1, PF, 32'hA000, 32'h4000), "squash_iret", 1'b1);

    // dc_exp without a valid instruction, and v_ro without dc_exp, do nothing.
    t = trig_in(0, 1, 0, 32'hE000, 0, 32'h6000);
    t.v_ro = 1'b0;
    cycle(t, mk(0, 0, 0, 0, PF, 32'hA000, 32'h4000), "mask_v", 1'b1);
    t = trig_in(0, 1, 0, 32'hE000, 0, 32'h6000);
    t.dc_exp = 1'b0;
    cycle(t, mk(0, 0, 0, 0, PF, 32'hA000, 32'h4000), "mask_exp", 1'b1);
    cycle(idle_in(1, 0), mk(0, 0, 0, 0, PF, 32'hA000, 32'h4000), "mask_after", 1'b1);

    // Reset in FLUSH aborts cleanly with no dispatch.
    cycle(trig_in(0, 1, 0, 32'h1234, 0, 32'h7000), mk(1, 0, 0, 0, PF, 32'hA000, 32'h4000), "rstf_trig", 1'b1);
    cycle(idle_in(1, 0), mk(1, 0, 0, 0, PF, 32'h1234, 32'h7000), "rstf_drain", 1'b1);
    t = idle_in(1, 0);
    t.rst = 1'b1;
    cycle(t, mk(1, 1, 0, 0, PF, 32'h1234, 32'h7000), "rstf_flush", 1'b1);
    cycle(idle_in(1, 0), mk(0, 0, 0, 0, 0, 0, 0), "rstf_after1", 1'b1);
    cycle(idle_in(1, 0), mk(0, 0, 0, 0, 0, 0, 0), "rstf_after2", 1'b1);

`ifdef DC_EXP_DOUBLE_FAULT_EN
    // Page fault, double fault inside the handler, then shutdown on the third trigger.
    cycle(trig_in(0, 1, 0, 32'h6000, 0, 32'h7000), mk(1, 0, 0, 0, 0, 0, 0), "df_trig1", 1'b1);
    cycle(idle_in(1, 0), mk(1, 0, 0, 0, PF, 32'h6000, 32'h7000), "df_drain1", 1'b1);
    for (int k = 0; k < FC; k++)
      cycle(idle_in(1, 0), mk(1, 1, 0, 0, PF, 32'h6000, 32'h7000), "df_flush1", 1'b1);
    cycle(idle_in(1, 0), mk(0, 0, 1, 0, PF, 32'h6000, 32'h7000), "df_disp1", 1'b1);
    cycle(idle_in(1, 0), mk(0, 0, 0, 1, PF, 32'h6000, 32'h7000), "df_isr1", 1'b1);
    cycle(trig_in(0, 1, 0, 32'h8000, 0, 32'h9000), mk(1, 0, 0, 1, PF, 32'h6000, 32'h7000), "df_trig2", 1'b1);
    cycle(idle_in(1, 0), mk(1, 0, 0, 1, DF, 0, 32'h9000), "df_drain2", 1'b1);
    for (int k = 0; k < FC; k++)
      cycle(idle_in(1, 0), mk(1, 1, 0, 1, DF, 0, 32'h9000), "df_flush2", 1'b1);
    cycle(idle_in(1, 0), mk(0, 0, 1, 1, DF, 0, 32'h9000), "df_disp2", 1'b1);
    cycle(idle_in(1, 0), mk(0, 0, 0, 1, DF, 0, 32'h9000), "df_isr2", 1'b1);
    cycle(trig_in(0, 1, 0, 32'hA000, 0, 32'hA000), mk(0, 0, 0, 1, DF, 0, 32'h9000), "df_trig3", 1'b1);
    s = mk(0, 0, 0, 1, 0, 0, 0);
    s.shut = 1'b1;
    for (int k = 0; k < 3; k++)
      cycle(idle_in(1, 1), s, "df_shutdown", 1'b1);
    do_reset();
    cycle(idle_in(1, 0), mk(0, 0, 0, 0, 0, 0, 0), "df_after_rst", 1'b1);
`endif

    // Randomized stimulus against the reference model.
    do_reset();
    m_reset();
    for (int n = 0; n < 1500; n++) begin
      t.rst    = ($urandom_range(0, 199) == 0);
      t.v_ro   = ($urandom_range(0, 1) == 0);
      t.dc_exp = ($urandom_range(0, 9) < 3);
      t.prot   = $urandom_range(0, 1);
      t.pf     = ~t.prot;
      t.rd     = $urandom_range(0, 1);
      t.wr     = $urandom_range(0, 1);
      t.rda    = $urandom;
      t.wra    = $urandom;
      t.eip    = $urandom;
      t.older  = ($urandom_range(0, 9) < 6);
      t.iret   = ($urandom_range(0, 19) < 3);
      @(posedge clk);
      #1 drive(t);
      @(negedge clk);
      check_out($sformatf("rnd%0d", n), m_out(t));
      m_step(t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
